// File: rtl/dm_param.sv
// dm_param: single-port word memory with byte/halfword/word access, fixed
// response latency and big-endian lane mapping.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req, we           request strobe (taken when ready=1), 1=store / 0=load
//   addr, size, sign  byte address, 00 byte / 01 half / 10 word, load extension
//   wdata             right-aligned store data
//   ready             idle and able to accept a request
//   rvalid, rdata     one-cycle response pulse and registered load result
//   err               fault flag, only meaningful with rvalid
module dm_param #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Request fields captured at acceptance
    logic        we_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [31:0] wdata_q;

    // Storage starts cleared for simulation; reset never touches it
    logic [31:0] mem [DEPTH] = '{default: '0};

    logic [AW-1:0] idx_c;
    logic [31:0]   word_c;
    logic          fault_c;
    logic [7:0]    byte_c;
    logic [15:0]   half_c;
    logic [31:0]   load_c;
    logic [31:0]   store_c;
    logic          finish_c;
    logic          commit_c;

    assign idx_c  = addr_q[AW+1:2];
    assign word_c = mem[idx_c];

    // Fault: illegal size, misalignment, or address beyond the array
    always_comb begin
        fault_c = 1'b0;
        case (size_q)
            2'b00:   fault_c = 1'b0;
            2'b01:   fault_c = addr_q[0];
            2'b10:   fault_c = (addr_q[1:0] != 2'b00);
            default: fault_c = 1'b1;
        endcase
        if ((addr_q >> (AW + 2)) != 32'd0) begin
            fault_c = 1'b1;
        end
    end

    // Load lane extraction, offset 0 is the most significant lane
    always_comb begin
        byte_c = 8'd0;
        case (addr_q[1:0])
            2'd0:    byte_c = word_c[31:24];
            2'd1:    byte_c = word_c[23:16];
            2'd2:    byte_c = word_c[15:8];
            default: byte_c = word_c[7:0];
        endcase
        half_c = addr_q[1] ? word_c[15:0] : word_c[31:16];
        case (size_q)
            2'b00:   load_c = sign_q ? {{24{byte_c[7]}}, byte_c} : {24'd0, byte_c};
            2'b01:   load_c = sign_q ? {{16{half_c[15]}}, half_c} : {16'd0, half_c};
            default: load_c = word_c;
        endcase
    end

    // Store merge: replace only the addressed lane(s) of the current word
    always_comb begin
        store_c = word_c;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'd0:    store_c[31:24] = wdata_q[7:0];
                    2'd1:    store_c[23:16] = wdata_q[7:0];
                    2'd2:    store_c[15:8]  = wdata_q[7:0];
                    default: store_c[7:0]   = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1]) begin
                    store_c[15:0] = wdata_q[15:0];
                end else begin
                    store_c[31:16] = wdata_q[15:0];
                end
            end
            default: store_c = wdata_q;
        endcase
    end

    // Last WAIT cycle; the store lands on the same edge that enters DONE
    assign finish_c = (state == WAIT) && (cnt == CW'(1));
    assign commit_c = finish_c && !rst && we_q && !fault_c;

    always_ff @(posedge clk) begin
        if (commit_c) begin
            mem[idx_c] <= store_c;
        end
    end

    // Control FSM with registered handshake and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ready   <= 1'b1;
            rvalid  <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            sign_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        size_q  <= size;
                        sign_q  <= sign;
                        wdata_q <= wdata;
                        cnt     <= CW'(LATENCY);
                        ready   <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == CW'(1)) begin
                        cnt    <= '0;
                        state  <= DONE;
                        rvalid <= 1'b1;
                        err    <= fault_c;
                        rdata  <= (fault_c || we_q) ? 32'd0 : load_c;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    rvalid <= 1'b0;
                    err    <= 1'b0;
                    ready  <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    rvalid <= 1'b0;
                    err    <= 1'b0;
                    ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_param.sv
// tb_dm_param: directed bench for dm_param. Main instance uses LATENCY=2;
// two extra instances (LATENCY=1 and 5) see a held request stream.
module tb_dm_param;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    logic        req_b;
    logic        ready1, rvalid1, err1;
    logic [31:0] rdata1;
    logic        ready5, rvalid5, err5;
    logic [31:0] rdata5;

    int checks = 0;
    int errors = 0;

    dm_param #(.DEPTH(1024), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .size(size),
        .sign(sign), .wdata(wdata), .ready(ready), .rvalid(rvalid),
        .rdata(rdata), .err(err)
    );

    dm_param #(.DEPTH(1024), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req(req_b), .we(1'b0), .addr(32'h10),
        .size(2'b10), .sign(1'b0), .wdata(32'h0), .ready(ready1),
        .rvalid(rvalid1), .rdata(rdata1), .err(err1)
    );

    dm_param #(.DEPTH(1024), .LATENCY(5)) u_l5 (
        .clk(clk), .rst(rst), .req(req_b), .we(1'b0), .addr(32'h10),
        .size(2'b10), .sign(1'b0), .wdata(32'h0), .ready(ready5),
        .rvalid(rvalid5), .rdata(rdata5), .err(err5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Issue one request; returns response data/err, edges from accept to
    // rvalid, and number of sampled cycles with ready low.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [1:0] s,
                          input logic sg, input logic [31:0] d,
                          output logic [31:0] rd, output logic e,
                          output int lat, output int busy);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req = 1'b1; we = w; addr = a; size = s; sign = sg; wdata = d;
        @(posedge clk);
        @(negedge clk);
        // scramble inputs; the captured copy must be used
        req = 1'b0; we = ~w; addr = 32'hFFFF_FFFF; size = 2'b11; sign = ~sg; wdata = ~d;
        lat = 0; busy = 0;
        while (!rvalid && lat < 40) begin
            if (!ready) busy++;
            @(negedge clk);
            lat++;
        end
        rd = rdata;
        e  = err;
        while (!ready && busy < 40) begin
            busy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; size = '0; sign = 1'b0;
        wdata = '0; req_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        rst = 1'b0;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic e; int lat, busy;
        do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'h1122_3344, rd, e, lat, busy);
        checks++; if (lat !== 2) begin errors++; $display("FAIL st_word_lat got %0d want 2", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL st_word_err got %b want 0", e); end
        checks++; if (busy !== 3) begin errors++; $display("FAIL st_word_busy got %0d want 3", busy); end
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, e, lat, busy);
        checks++; if (rd !== 32'h1122_3344) begin errors++; $display("FAIL ld_word_data got %h want 11223344", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL ld_word_err got %b want 0", e); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL ld_word_lat got %0d want 2", lat); end
        checks++; if (busy !== 3) begin errors++; $display("FAIL ld_word_busy got %0d want 3", busy); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse got %b want 0", rvalid); end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic e; int lat, busy;
        do_req(1'b1, 32'h12, 2'b00, 1'b0, 32'h1234_56AB, rd, e, lat, busy);
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, e, lat, busy);
        checks++; if (rd !== 32'h1122_AB44) begin errors++; $display("FAIL byte_word got %h want 1122ab44", rd); end
        do_req(1'b0, 32'h12, 2'b00, 1'b1, 32'h0, rd, e, lat, busy);
        checks++; if (rd !== 32'hFFFF_FFAB) begin errors++; $display("FAIL byte_signed got %h want ffffffab", rd); end
        do_req(1'b0, 32'h12, 2'b00, 1'b0, 32'h0, rd, e, lat, busy);
        checks++; if (rd !== 32'h0000_00AB) begin errors++; $display("FAIL byte_unsigned got %h want 000000ab", rd); end
        do_req(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, rd, e, lat, busy);
        checks++; if (rd !== 32'h0000_0044) begin errors++; $display("FAIL byte_off3 got %h want 00000044", rd); end
        do_req(1'b0, 32'h10, 2'b00, 1'b0, 32'h0, rd, e, lat, busy);
        checks++; if (rd !== 32'h0000_0011) begin errors++; $display("FAIL byte_off0 got %h want 00000011", rd); end
        do_req(1'b0, 32'h11, 2'b00, 1'b0, 32'h0, rd, e, lat, busy);
        checks++; if (rd !== 32'h0000_0022) begin errors++; $display("FAIL byte_off1 got %h want 00000022", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic e; int lat, busy;
        do_req(1'b1, 32'h10, 2'b01, 1'b0, 32'h0000_8001, rd, e, lat, busy);
        do_req(1'b0, 32'h10, 2'b01, 1'b1, 32'h0, rd, e, lat, busy);
        checks++; if (rd !== 32'hFFFF_8001) begin errors++; $display("FAIL half_signed got %h want ffff8001", rd); end
        do_req(1'b0, 32'h10, 2'b01, 1'b0, 32'h0, rd, e, lat, busy);
        checks++; if (rd !== 32'h0000_8001) begin errors++; $display("FAIL half_unsigned got %h want 00008001", rd); end
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, e, lat, busy);
        checks++; if (rd !== 32'h8001_AB44) begin errors++; $display("FAIL half_word got %h want 8001ab44", rd); end
        do_req(1'b0, 32'h12, 2'b01, 1'b1, 32'h0, rd, e, lat, busy);
        checks++; if (rd !== 32'hFFFF_AB44) begin errors++; $display("FAIL half_hi_signed got %h want ffffab44", rd); end
        do_req(1'b0, 32'h12, 2'b10, 1'b1, 32'h0, rd, e, lat, busy);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL word_off2_err got %b want 1", e); end
    endtask

    task automatic test_fault();
        logic [31:0] rd; logic e; int lat, busy;
        do_req(1'b0, 32'h13, 2'b10, 1'b0, 32'h0, rd, e, lat, busy);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL flt_ldw13_err got %b want 1", e); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL flt_ldw13_data got %h want 0", rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL flt_ldw13_lat got %0d want 2", lat); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL flt_err_after got %b want 0", err); end
        do_req(1'b1, 32'h11, 2'b01, 1'b0, 32'h0000_5555, rd, e, lat, busy);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL flt_sth11_err got %b want 1", e); end
        do_req(1'b0, 32'h1000, 2'b00, 1'b0, 32'h0, rd, e, lat, busy);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL flt_ld1000_err got %b want 1", e); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL flt_ld1000_data got %h want 0", rd); end
        // 0x1010 would alias word 0x10 if the range check were missing
        do_req(1'b1, 32'h1010, 2'b10, 1'b0, 32'hCAFE_F00D, rd, e, lat, busy);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL flt_st1010_err got %b want 1", e); end
        do_req(1'b1, 32'h10, 2'b11, 1'b0, 32'h7777_7777, rd, e, lat, busy);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL flt_size11_err got %b want 1", e); end
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, e, lat, busy);
        checks++; if (rd !== 32'h8001_AB44) begin errors++; $display("FAIL flt_mem_kept got %h want 8001ab44", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL flt_mem_kept_err got %b want 0", e); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic e; int lat, busy, seen;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; size = 2'b10; sign = 1'b0; wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", ready); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL abort_rvalid got %b want 0", rvalid); end
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rvalid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_rvalid got %0d want 0", seen); end
        do_req(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, rd, e, lat, busy);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_no_store got %h want 0", rd); end
    endtask

    task automatic test_rst_priority();
        int seen;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h10; size = 2'b10; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; rst = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL prio_ready got %b want 1", ready); end
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rvalid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL prio_no_rvalid got %0d want 0", seen); end
    endtask

    task automatic test_back_to_back();
        int acc1, acc5, rv1, rv5, last1, last5;
        acc1 = 0; acc5 = 0; rv1 = 0; rv5 = 0; last1 = -1; last5 = -1;
        @(negedge clk);
        req_b = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 59) req_b = 1'b0;
            if (rvalid1) begin
                if (last1 >= 0) begin
                    checks++;
                    if (c - last1 !== 3) begin errors++; $display("FAIL b2b_l1_spacing got %0d want 3", c - last1); end
                end
                last1 = c; rv1++;
            end
            if (rvalid5) begin
                if (last5 >= 0) begin
                    checks++;
                    if (c - last5 !== 7) begin errors++; $display("FAIL b2b_l5_spacing got %0d want 7", c - last5); end
                end
                last5 = c; rv5++;
            end
            if (err1 !== 1'b0 || err5 !== 1'b0) begin
                checks++; errors++;
                $display("FAIL b2b_err got %b/%b want 0/0", err1, err5);
            end
            if (ready1 && req_b) acc1++;
            if (ready5 && req_b) acc5++;
        end
        checks++; if (rv1 !== acc1 || rv1 < 15) begin errors++; $display("FAIL b2b_l1_count got %0d rvalid want %0d accepts (>=15)", rv1, acc1); end
        checks++; if (rv5 !== acc5 || rv5 < 7) begin errors++; $display("FAIL b2b_l5_count got %0d rvalid want %0d accepts (>=7)", rv5, acc5); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_fault();
        test_reset_abort();
        test_rst_priority();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_param.md
DM_PARAM -- requirements
Module: dm_param

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 32-bit words (power of two, >=2).
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles between acceptance and response (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  1  request strobe, sampled only when ready=1.
REQ-006 SHALL have port we  input  1  1=store, 0=load.
REQ-007 SHALL have port addr  input  32  byte address; word index = addr[log2(DEPTH)+1:2].
REQ-008 SHALL have port size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 SHALL have port sign  input  1  load extension: 1 sign-extend, 0 zero-extend; ignored for word and stores.
REQ-010 SHALL have port wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port ready  output  1  high when idle and able to accept.
REQ-012 SHALL have port rvalid  output  1  one-cycle response pulse for every accepted request.
REQ-013 SHALL have port rdata  output  32  load result, valid only with rvalid.
REQ-014 SHALL have port err  output  1  asserted with rvalid when the request faulted.

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> DONE -> IDLE; ready=1 only in IDLE; rvalid=1 only in DONE.
REQ-016 SHALL accept a request on an edge where req=1 and ready=1, registering we, addr, size, sign, wdata; later input changes are ignored until the next acceptance.
REQ-017 SHALL stay in WAIT for exactly LATENCY cycles (down-counter), so rvalid is high in the cycle starting LATENCY edges after the accept edge; ready returns high one cycle later (issue interval LATENCY+2 cycles).
REQ-018 SHALL use big-endian lanes: byte offset 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0]; halfword offset 0 -> [31:16], 2 -> [15:0].
REQ-019 SHALL commit a store on the edge entering DONE, writing only the addressed lane(s); other bytes of the word are unchanged.
REQ-020 SHALL, for loads, extract the addressed lane into rdata low bits and sign- or zero-extend per sign; word loads return the full word; rdata is registered and held until the next DONE.
REQ-021 SHALL flag a fault when: size=11; halfword with addr[0]=1; word with addr[1:0]!=00; or addr[31:log2(DEPTH)+2] nonzero.
REQ-022 SHALL, on fault, still traverse WAIT/DONE with normal timing, assert err=1 with rvalid, drive rdata=0, and leave memory unchanged.
REQ-023 SHALL drive err=0 whenever rvalid=0.
REQ-024 SHALL ignore req while ready=0 (no queuing, no error).
REQ-025 SHALL initialise all memory words to 0 at time zero for simulation; contents are NOT affected by rst.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, force IDLE, counter=0, ready=1, rvalid=0, err=0, rdata=0.
REQ-027 SHALL, on rst during WAIT, abort the operation: no store commits, no rvalid for it.
REQ-028 SHALL give rst priority over a simultaneous req (the request is not accepted).

Verification
REQ-029 SHALL pass: store word 0x11223344 @0x10, then load word @0x10 -> rvalid exactly 2 cycles after accept, rdata=0x11223344, err=0; ready low for 3 cycles.
REQ-030 SHALL pass: after REQ-029, store byte 0xAB @0x12, load word @0x10 -> 0x1122AB44; load byte signed @0x12 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
REQ-031 SHALL pass: store half 0x8001 @0x10, load half signed @0x10 -> 0xFFFF8001; unsigned -> 0x00008001; word @0x10 -> 0x8001AB44.
REQ-032 SHALL pass: load word @0x13, store half @0x11, and any access @0x1000 (DEPTH=1024) -> err=1 with rvalid, rdata=0, memory word @0x10 unchanged.
REQ-033 SHALL pass: store word 0xDEADBEEF @0x20, rst pulsed one cycle after accept -> no rvalid, ready=1 next cycle, load @0x20 returns 0x00000000.
REQ-034 SHALL pass: with LATENCY=1 and LATENCY=5 builds, back-to-back requests held on req -> rvalid spacing LATENCY+2 cycles, one rvalid per accepted request.
